// File: rtl/vote_logger.sv
// Per-candidate vote accumulator with post-vote lockout, multi-press rejection and result readout.
// Optional macro VOTE_SATURATE_EN: counters hold at their maximum instead of wrapping.
module vote_logger #(
  parameter int NUM_CAND       = 4,
  parameter int CNT_W          = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int SEL_W          = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [NUM_CAND-1:0] valid_vote,
  input  logic [SEL_W-1:0]    sel,
  output logic [CNT_W-1:0]    result,
  output logic                vote_ack,
  output logic                reject,
  output logic [NUM_CAND-1:0] vote_led,
  output logic                busy
);

  localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_CAND);

  typedef enum logic [1:0] {VOTE, LOCK, RESULT} state_t;

  state_t              state, state_next;
  logic [TMR_W-1:0]    timer, timer_next;
  logic [CNT_W-1:0]    counters [NUM_CAND];
  logic [CNT_W-1:0]    result_next;
  logic [CNT_W-1:0]    sel_count;
  logic [NUM_CAND-1:0] led_next;
  logic [IDX_W-1:0]    vote_idx;
  logic                single_vote;
  logic                ack_next, reject_next, inc_en;

  // A non-zero value with no second bit set is a legal single press.
  assign single_vote = (valid_vote != '0) &&
                       ((valid_vote & (valid_vote - NUM_CAND'(1))) == '0);

  always_comb begin
    vote_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (valid_vote[i]) vote_idx = IDX_W'(i);
    end
  end

  // Out-of-range selections read as zero.
  always_comb begin
    sel_count = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (int'(sel) == i) sel_count = counters[i];
    end
  end

  always_comb begin
    state_next  = state;
    timer_next  = timer;
    ack_next    = 1'b0;
    reject_next = 1'b0;
    led_next    = vote_led;
    result_next = '0;
    inc_en      = 1'b0;
    case (state)
      VOTE: begin
        if (mode) begin
          state_next = RESULT;
        end else if (single_vote) begin
          inc_en     = 1'b1;
          ack_next   = 1'b1;
          led_next   = valid_vote;
          timer_next = TMR_W'(LOCKOUT_CYCLES - 1);
          state_next = LOCK;
        end else if (valid_vote != '0) begin
          reject_next = 1'b1;
        end
      end
      LOCK: begin
        if (timer == '0) begin
          state_next = VOTE;
          led_next   = '0;
        end else begin
          timer_next = timer - TMR_W'(1);
        end
      end
      RESULT: begin
        if (mode) result_next = sel_count;
        else      state_next  = VOTE;
      end
      default: state_next = VOTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= VOTE;
      timer    <= '0;
      vote_ack <= 1'b0;
      reject   <= 1'b0;
      vote_led <= '0;
      result   <= '0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      vote_ack <= ack_next;
      reject   <= reject_next;
      vote_led <= led_next;
      result   <= result_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) counters[i] <= '0;
    end else if (inc_en) begin
`ifdef VOTE_SATURATE_EN
      if (counters[vote_idx] != '1) counters[vote_idx] <= counters[vote_idx] + CNT_W'(1);
`else
      counters[vote_idx] <= counters[vote_idx] + CNT_W'(1);
`endif
    end
  end

  assign busy = (state != VOTE);

endmodule

// File: tb/tb_vote_logger.sv
// Self-checking bench for vote_logger: directed scenarios plus random traffic against an
// edge-indexed behavioural model (true vote totals, lockout tracked by edge distance).
module tb_vote_logger;
  localparam int NUM_CAND       = 4;
  localparam int CNT_W          = 8;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int SEL_W          = 2;
  localparam int CNT_MAX        = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                mode = 1'b0;
  logic [NUM_CAND-1:0] valid_vote = '0;
  logic [SEL_W-1:0]    sel = '0;
  logic [CNT_W-1:0]    result;
  logic                vote_ack;
  logic                reject;
  logic [NUM_CAND-1:0] vote_led;
  logic                busy;

  vote_logger #(
    .NUM_CAND(NUM_CAND), .CNT_W(CNT_W), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .valid_vote(valid_vote), .sel(sel),
    .result(result), .vote_ack(vote_ack), .reject(reject), .vote_led(vote_led), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int                  totals [NUM_CAND];
  int                  edgeNum = 0;
  int                  lastAccept = -1000;
  bit                  inResult = 1'b0;
  logic [NUM_CAND-1:0] lastLed = '0;
  int                  expResult = 0;
  bit                  expAck = 1'b0;
  bit                  expReject = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, edgeNum, observed, expected);
    end
  endtask

  function automatic int shownCount(input int total);
`ifdef VOTE_SATURATE_EN
    return (total > CNT_MAX) ? CNT_MAX : total;
`else
    return total % (CNT_MAX + 1);
`endif
  endfunction

  // Reference behaviour for one rising edge with the given inputs.
  task automatic modelEdge(input bit rst, input bit md, input logic [NUM_CAND-1:0] vv, input int s);
    bit locked;
    expAck = 1'b0;
    expReject = 1'b0;
    expResult = 0;
    if (rst) begin
      for (int i = 0; i < NUM_CAND; i++) totals[i] = 0;
      inResult = 1'b0;
      lastAccept = -1000;
      lastLed = '0;
      return;
    end
    locked = (edgeNum - 1 - lastAccept) < LOCKOUT_CYCLES;
    if (inResult) begin
      if (md) expResult = (s < NUM_CAND) ? shownCount(totals[s]) : 0;
      inResult = md;
    end else if (!locked) begin
      if (md) begin
        inResult = 1'b1;
      end else if ($countones(vv) == 1) begin
        for (int i = 0; i < NUM_CAND; i++) if (vv[i]) totals[i]++;
        lastAccept = edgeNum;
        lastLed = vv;
        expAck = 1'b1;
      end else if ($countones(vv) > 1) begin
        expReject = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit md, input logic [NUM_CAND-1:0] vv,
                               input logic [SEL_W-1:0] s);
    bit lockNow;
    reset = rst;
    mode = md;
    valid_vote = vv;
    sel = s;
    @(posedge clk);
    edgeNum++;
    modelEdge(rst, md, vv, int'(s));
    lockNow = (edgeNum - lastAccept) < LOCKOUT_CYCLES;
    #1;
    checkOutput("vote_ack", 32'(vote_ack), 32'(expAck));
    checkOutput("reject", 32'(reject), 32'(expReject));
    checkOutput("busy", 32'(busy), 32'(inResult || lockNow));
    checkOutput("vote_led", 32'(vote_led), lockNow ? 32'(lastLed) : 32'd0);
    checkOutput("result", 32'(result), 32'(expResult));
    reset = 1'b0;
    valid_vote = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int r;
    bit md;
    logic [NUM_CAND-1:0] vv;

    // Reset state and single vote.
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 4'b0010, '0);
    idle(LOCKOUT_CYCLES + 1);
    applyStimulus(1'b0, 1'b1, '0, 2'd1);
    applyStimulus(1'b0, 1'b1, '0, 2'd1);
    checkOutput("single_vote_cand1", 32'(result), 32'd1);
    applyStimulus(1'b0, 1'b1, '0, 2'd0);
    checkOutput("single_vote_cand0", 32'(result), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, '0);

    // Lockout drop, then acceptance at k+LOCKOUT_CYCLES+1.
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 4'b0001, '0);
    idle(4);
    applyStimulus(1'b0, 1'b0, 4'b0100, '0);
    idle(LOCKOUT_CYCLES - 5);
    applyStimulus(1'b0, 1'b0, 4'b0100, '0);
    checkOutput("late_vote_ack", 32'(vote_ack), 32'd1);
    idle(LOCKOUT_CYCLES);

    // Simultaneous presses.
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 4'b0110, '0);
    idle(2);

    // Mode priority and readout latency across all selections.
    applyStimulus(1'b0, 1'b1, 4'b1000, 2'd3);
    for (int i = 0; i < NUM_CAND; i++) applyStimulus(1'b0, 1'b1, '0, SEL_W'(i));
    applyStimulus(1'b0, 1'b0, '0, '0);

    // Counter overflow on candidate 0.
    applyStimulus(1'b1, 1'b0, '0, '0);
    for (int v = 0; v < 256; v++) begin
      applyStimulus(1'b0, 1'b0, 4'b0001, '0);
      idle(LOCKOUT_CYCLES);
    end
    applyStimulus(1'b0, 1'b1, '0, 2'd0);
    applyStimulus(1'b0, 1'b1, '0, 2'd0);
`ifdef VOTE_SATURATE_EN
    checkOutput("overflow_cand0", 32'(result), 32'd255);
`else
    checkOutput("overflow_cand0", 32'(result), 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, '0, '0);

    // Reset during lockout, then immediate new vote.
    applyStimulus(1'b0, 1'b0, 4'b0001, '0);
    idle(3);
    applyStimulus(1'b1, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 4'b1000, '0);
    checkOutput("post_reset_ack", 32'(vote_ack), 32'd1);
    idle(LOCKOUT_CYCLES);

    // Random traffic.
    md = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) md = ~md;
      r = $urandom_range(0, 9);
      if (r < 5)      vv = '0;
      else if (r < 8) vv = NUM_CAND'(1) << $urandom_range(0, NUM_CAND - 1);
      else            vv = NUM_CAND'($urandom);
      applyStimulus($urandom_range(0, 199) == 0, md, vv, SEL_W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
